// File: rtl/q_avg_sequencer.sv
// Drives the measurement stage through 2**N_AVG_LOG2 samples and presents their average.
// Optional round-half-up averaging when Q_AVG_ROUND_EN is defined.
module q_avg_sequencer #(
    parameter int unsigned BUS_WIDTH  = 10,
    parameter int unsigned N_AVG_LOG2 = 2,
    parameter int unsigned TMO_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 ready,
    input  logic [BUS_WIDTH-1:0] q_measured,
    output logic                 start,
    output logic [BUS_WIDTH-1:0] q_avg,
    output logic                 avg_valid,
    input  logic                 avg_ack,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned ACC_W  = BUS_WIDTH + N_AVG_LOG2;
    localparam int unsigned CNT_W  = (N_AVG_LOG2 == 0) ? 1 : N_AVG_LOG2;
    localparam int unsigned N_SAMP = 1 << N_AVG_LOG2;
`ifdef Q_AVG_ROUND_EN
    localparam int unsigned RND    = (1 << N_AVG_LOG2) >> 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        CAPTURE,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [ACC_W-1:0]     acc, acc_nxt, acc_sum, avg_full;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [TMO_WIDTH-1:0] tmo, tmo_nxt;
    logic [BUS_WIDTH-1:0] q_avg_nxt;
    logic                 terr_nxt;

    // Timeout fires in the MEASURE cycle that completes 2**TMO_WIDTH-1 cycles.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = {TMO_WIDTH{1'b1}} - TMO_WIDTH'(1);

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        q_avg_nxt = q_avg;
        terr_nxt  = timeout_err;
        acc_sum   = acc + ACC_W'(q_measured);
`ifdef Q_AVG_ROUND_EN
        avg_full  = (acc_sum + ACC_W'(RND)) >> N_AVG_LOG2;
`else
        avg_full  = acc_sum >> N_AVG_LOG2;
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = ARM;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    terr_nxt  = 1'b0;
                end
            end
            ARM: begin
                tmo_nxt   = '0;
                state_nxt = enable ? MEASURE : IDLE;
            end
            MEASURE: begin
                tmo_nxt = tmo + TMO_WIDTH'(1);
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (ready) begin
                    state_nxt = CAPTURE;
                end else if (tmo == TMO_LAST) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = acc_sum;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_SAMP - 1)) begin
                        q_avg_nxt = BUS_WIDTH'(avg_full);
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ARM;
                    end
                end
            end
            DONE: begin
                if (avg_ack) begin
                    if (enable) begin
                        state_nxt = ARM;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            tmo         <= '0;
            q_avg       <= '0;
            timeout_err <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            avg_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            tmo         <= tmo_nxt;
            q_avg       <= q_avg_nxt;
            timeout_err <= terr_nxt;
            start       <= (state_nxt == MEASURE) || (state_nxt == CAPTURE);
            busy        <= (state_nxt != IDLE);
            avg_valid   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_q_avg_sequencer.sv
// Directed bench for q_avg_sequencer with a measurement-stage model and an average scoreboard.
module tb_q_avg_sequencer;

    localparam int unsigned BW  = 10;
    localparam int unsigned NL2 = 2;
    localparam int unsigned TW  = 4;
    localparam int          DLY = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic [BW-1:0] q_measured = '0;
    logic          start;
    logic [BW-1:0] q_avg;
    logic          avg_valid;
    logic          avg_ack = 1'b0;
    logic          busy;
    logic          timeout_err;

    int compared = 0;
    int mismatched = 0;

    int mq[$];
    int exp_q[$];
    bit no_ready = 1'b0;
    int mcnt = 0;
    int arm_cycles;
    int arm_run;
    int arm_max;

    q_avg_sequencer #(.BUS_WIDTH(BW), .N_AVG_LOG2(NL2), .TMO_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ready(ready), .q_measured(q_measured),
        .start(start), .q_avg(q_avg), .avg_valid(avg_valid), .avg_ack(avg_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Measurement stage: cleared while start=0, ready DLY cycles after start rises.
    always @(negedge clk) begin
        if (!start) begin
            mcnt  = 0;
            ready = 1'b0;
        end else begin
            if (mcnt < 1000) mcnt = mcnt + 1;
            if (mcnt == DLY && !no_ready) begin
                ready = 1'b1;
                q_measured = (mq.size() > 0) ? BW'(mq.pop_front()) : '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int avg4(input int a, input int b, input int c, input int d);
`ifdef Q_AVG_ROUND_EN
        return (a + b + c + d + 2) / 4;
`else
        return (a + b + c + d) / 4;
`endif
    endfunction

    task automatic load4(input int a, input int b, input int c, input int d);
        mq.push_back(a); mq.push_back(b); mq.push_back(c); mq.push_back(d);
        exp_q.push_back(avg4(a, b, c, d));
    endtask

    // Wait for avg_valid, tracking ARM cycles (busy with start low, not in DONE).
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        arm_cycles = 0; arm_run = 0; arm_max = 0;
        while (!avg_valid && n < 500) begin
            tick();
            n++;
            if (busy && !start && !avg_valid) begin
                arm_cycles++;
                arm_run++;
                if (arm_run > arm_max) arm_max = arm_run;
            end else begin
                arm_run = 0;
            end
        end
        chk({tag, "_valid_seen"}, 32'(avg_valid), 32'd1);
    endtask

    task automatic check_avg(input string tag);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk(tag, 32'(q_avg), 32'(e));
    endtask

    task automatic ack_pulse();
        avg_ack = 1'b1;
        tick();
        avg_ack = 1'b0;
    endtask

    initial begin
        int hi;
        int n;

        #12;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_q_avg", 32'(q_avg), 32'd0);
        chk("rst_avg_valid", 32'(avg_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        tick();

        // Basic average: 90,120,150,60 -> 105
        load4(90, 120, 150, 60);
        enable = 1'b1;
        wait_valid("basic");
        chk("basic_arm_cycles", 32'(arm_cycles), 32'd4);
        chk("basic_arm_run", 32'(arm_max), 32'd1);
        check_avg("basic_q_avg");
        enable = 1'b0;
        repeat (3) tick();
        chk("basic_held_valid", 32'(avg_valid), 32'd1);
        chk("basic_held_q", 32'(q_avg), 32'd105);
        chk("basic_done_start", 32'(start), 32'd0);
        ack_pulse();
        chk("basic_ack_valid", 32'(avg_valid), 32'd0);
        chk("basic_ack_busy", 32'(busy), 32'd0);

        // Truncation vs rounding
        load4(30, 31, 31, 31);
        enable = 1'b1;
        wait_valid("round");
        check_avg("round_q_avg");
        enable = 1'b0;
        ack_pulse();

        // Full-scale samples
        load4(1023, 1023, 1023, 1023);
        enable = 1'b1;
        wait_valid("full");
        check_avg("full_q_avg");
        enable = 1'b0;
        ack_pulse();

        // Back-to-back with enable held
        load4(90, 120, 150, 60);
        load4(10, 20, 30, 40);
        enable = 1'b1;
        wait_valid("b2b1");
        check_avg("b2b1_q_avg");
        repeat (3) tick();
        ack_pulse();
        chk("b2b_valid_drop", 32'(avg_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        ack_pulse();
        chk("stray_ack_busy", 32'(busy), 32'd1);
        wait_valid("b2b2");
        check_avg("b2b2_q_avg");
        enable = 1'b0;
        ack_pulse();

        // Timeout with ready never asserted
        no_ready = 1'b1;
        enable = 1'b1;
        hi = 0;
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
            if (start) hi++;
        end
        enable = 1'b0;
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_measure_cycles", 32'(hi), 32'd15);
        chk("tmo_start", 32'(start), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_avg_valid", 32'(avg_valid), 32'd0);
        repeat (2) tick();
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        no_ready = 1'b0;
        load4(30, 31, 31, 31);
        enable = 1'b1;
        tick();
        chk("tmo_clear_on_arm", 32'(timeout_err), 32'd0);
        wait_valid("tmo_recover");
        check_avg("tmo_recover_q_avg");
        enable = 1'b0;
        ack_pulse();

        // enable dropped in the third sample's MEASURE
        mq.push_back(200); mq.push_back(300); mq.push_back(400); mq.push_back(500);
        enable = 1'b1;
        arm_cycles = 0;
        n = 0;
        while (arm_cycles < 3 && n < 200) begin
            tick();
            n++;
            if (busy && !start && !avg_valid) arm_cycles++;
        end
        repeat (2) tick();
        chk("abort_in_measure", 32'(start), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_start", 32'(start), 32'd0);
        chk("abort_avg_valid", 32'(avg_valid), 32'd0);
        repeat (3) tick();
        chk("abort_no_valid", 32'(avg_valid), 32'd0);
        mq.delete();

        // Asynchronous reset during CAPTURE
        load4(100, 100, 100, 100);
        enable = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("cap_start", 32'(start), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_q_avg", 32'(q_avg), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_avg_valid", 32'(avg_valid), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
